// File: rtl/cla_pipe_adder.sv
// Pipelined two-level carry-lookahead adder/subtractor with a valid/ready handshake.
// Stage s resolves GPS groups; one global advance moves every stage register together.
module cla_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   cin,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       sum,
  output logic                   cout,
  output logic                   ovf,
  output logic                   zero,
  output logic [WIDTH/GROUP-1:0] gg,
  output logic [WIDTH/GROUP-1:0] gp
);
  localparam int NG  = WIDTH / GROUP;
  localparam int GPS = NG / STAGES;
  localparam int SW  = GPS * GROUP;

  // Level 0 holds the raw beat; level s+1 holds the result of stage s.
  logic             valid_q [STAGES+1];
  logic             carry_q [STAGES+1];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [NG-1:0]    gg_q    [STAGES];
  logic [NG-1:0]    gp_q    [STAGES];
  logic             zero_q;
  logic             ovf_q;

  logic             carry_d [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic [NG-1:0]    gg_d    [STAGES];
  logic [NG-1:0]    gp_d    [STAGES];
  logic             msb_carry_d;
  logic             adv;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [SW-1:0]    sa, sb, sg, sp, sc;
    logic [GPS-1:0]   grp_g, grp_p;
    logic [GPS:0]     gcar;
    logic [WIDTH-1:0] prev_sum, nsum;
    logic [NG-1:0]    prev_gg, prev_gp, ngg, ngp;

    assign sa = a_q[gi][gi*SW +: SW];
    assign sb = b_q[gi][gi*SW +: SW];
    assign sg = sa & sb;
    assign sp = sa ^ sb;

    if (gi == 0) begin : g_first
      assign prev_sum = '0;
      assign prev_gg  = '0;
      assign prev_gp  = '0;
    end else begin : g_rest
      assign prev_sum = sum_q[gi-1];
      assign prev_gg  = gg_q[gi-1];
      assign prev_gp  = gp_q[gi-1];
    end

    // Every carry is an explicit sum of generate terms masked by propagate products.
    always_comb begin : p_lookahead
      logic t;
      t     = 1'b0;
      grp_g = '0;
      grp_p = '0;
      gcar  = '0;
      sc    = '0;
      for (int j = 0; j < GPS; j++) begin
        grp_p[j] = &sp[j*GROUP +: GROUP];
        for (int k = 0; k < GROUP; k++) begin
          t = sg[j*GROUP+k];
          for (int n = k + 1; n < GROUP; n++) t = t & sp[j*GROUP+n];
          grp_g[j] = grp_g[j] | t;
        end
      end
      gcar[0] = carry_q[gi];
      for (int j = 1; j <= GPS; j++) begin
        t = carry_q[gi];
        for (int n = 0; n < j; n++) t = t & grp_p[n];
        gcar[j] = t;
        for (int m = 0; m < j; m++) begin
          t = grp_g[m];
          for (int n = m + 1; n < j; n++) t = t & grp_p[n];
          gcar[j] = gcar[j] | t;
        end
      end
      for (int j = 0; j < GPS; j++) begin
        for (int k = 0; k < GROUP; k++) begin
          t = gcar[j];
          for (int n = 0; n < k; n++) t = t & sp[j*GROUP+n];
          sc[j*GROUP+k] = t;
          for (int m = 0; m < k; m++) begin
            t = sg[j*GROUP+m];
            for (int n = m + 1; n < k; n++) t = t & sp[j*GROUP+n];
            sc[j*GROUP+k] = sc[j*GROUP+k] | t;
          end
        end
      end
    end

    always_comb begin : p_merge
      nsum = prev_sum;
      nsum[gi*SW +: SW] = sp ^ sc;
      ngg = prev_gg;
      ngg[gi*GPS +: GPS] = grp_g;
      ngp = prev_gp;
      ngp[gi*GPS +: GPS] = grp_p;
    end

    assign sum_d[gi]   = nsum;
    assign gg_d[gi]    = ngg;
    assign gp_d[gi]    = ngp;
    assign carry_d[gi] = gcar[GPS];

    if (gi == STAGES - 1) begin : g_top
      assign msb_carry_d = sc[SW-1];
    end
  end

  assign adv      = ~valid_q[STAGES] | out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= STAGES; s++) begin
        valid_q[s] <= 1'b0;
        carry_q[s] <= 1'b0;
      end
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
        gg_q[s]  <= '0;
        gp_q[s]  <= '0;
      end
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (adv) begin
      valid_q[0] <= in_valid;
      carry_q[0] <= sub | cin;
      a_q[0]     <= a;
      b_q[0]     <= b ^ {WIDTH{sub}};
      for (int s = 0; s < STAGES; s++) begin
        valid_q[s+1] <= valid_q[s];
        carry_q[s+1] <= carry_d[s];
        sum_q[s]     <= sum_d[s];
        gg_q[s]      <= gg_d[s];
        gp_q[s]      <= gp_d[s];
      end
      for (int s = 1; s < STAGES; s++) begin
        a_q[s] <= a_q[s-1];
        b_q[s] <= b_q[s-1];
      end
      zero_q <= ~|sum_d[STAGES-1];
      ovf_q  <= msb_carry_d ^ carry_d[STAGES-1];
    end
  end

  assign out_valid = valid_q[STAGES];
  assign sum       = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES];
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign gg        = gg_q[STAGES-1];
  assign gp        = gp_q[STAGES-1];
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed vector table, back-pressure stream, mid-flight reset,
// and random streams on the default build and a 64-bit, 8-stage build.
module tb_cla_pipe_adder;
  localparam int STG = 2;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [3:0]  gg;
    logic [3:0]  gp;
  } vec_t;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [15:0] gg;
    logic [15:0] gp;
  } res_t;

  logic clk, rst_n;
  int n_checks = 0;
  int n_fail   = 0;

  logic        d1_iv, d1_ir, d1_ov, d1_ordy, d1_cin, d1_sub, d1_cout, d1_ovf, d1_zero;
  logic [15:0] d1_a, d1_b, d1_sum;
  logic [3:0]  d1_gg, d1_gp;
  logic        d2_iv, d2_ir, d2_ov, d2_ordy, d2_cin, d2_sub, d2_cout, d2_ovf, d2_zero;
  logic [63:0] d2_a, d2_b, d2_sum;
  logic [15:0] d2_gg, d2_gp;

  cla_pipe_adder #(.WIDTH(16), .GROUP(4), .STAGES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(d1_iv), .in_ready(d1_ir), .a(d1_a), .b(d1_b),
    .cin(d1_cin), .sub(d1_sub), .out_valid(d1_ov), .out_ready(d1_ordy), .sum(d1_sum),
    .cout(d1_cout), .ovf(d1_ovf), .zero(d1_zero), .gg(d1_gg), .gp(d1_gp)
  );

  cla_pipe_adder #(.WIDTH(64), .GROUP(4), .STAGES(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(d2_iv), .in_ready(d2_ir), .a(d2_a), .b(d2_b),
    .cin(d2_cin), .sub(d2_sub), .out_valid(d2_ov), .out_ready(d2_ordy), .sum(d2_sum),
    .cout(d2_cout), .ovf(d2_ovf), .zero(d2_zero), .gg(d2_gg), .gp(d2_gp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain wide addition; group G is the carry out of the isolated group sum.
  function automatic res_t model(input logic [63:0] av, input logic [63:0] bv, input logic ci,
                                 input logic sb, input int w, input int gr);
    res_t r;
    logic [63:0] mask, be, aa, gm, ga, gb;
    logic [64:0] full, low;
    logic ce;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa   = av & mask;
    be   = (sb ? ~bv : bv) & mask;
    ce   = sb | ci;
    full = {1'b0, aa} + {1'b0, be} + {64'd0, ce};
    low  = {1'b0, aa & (mask >> 1)} + {1'b0, be & (mask >> 1)} + {64'd0, ce};
    r.sum  = full[63:0] & mask;
    r.cout = full[w];
    r.ovf  = low[w-1] ^ full[w];
    r.zero = (r.sum == 64'd0);
    r.gg   = '0;
    r.gp   = '0;
    gm = (64'd1 << gr) - 64'd1;
    for (int g = 0; g < w / gr; g++) begin
      ga = (aa >> (g * gr)) & gm;
      gb = (be >> (g * gr)) & gm;
      r.gg[g] = (((ga + gb) >> gr) != 64'd0);
      r.gp[g] = ((ga ^ gb) == gm);
    end
    return r;
  endfunction

  task automatic drive(input bit big, input logic iv, input logic [63:0] av, input logic [63:0] bv,
                       input logic ci, input logic sb, input logic ordy);
    if (big) begin
      d2_iv = iv; d2_a = av; d2_b = bv; d2_cin = ci; d2_sub = sb; d2_ordy = ordy;
    end else begin
      d1_iv = iv; d1_a = av[15:0]; d1_b = bv[15:0]; d1_cin = ci; d1_sub = sb; d1_ordy = ordy;
    end
  endtask

  task automatic sample(input bit big, output logic ir, output logic ov, output res_t r);
    if (big) begin
      ir = d2_ir; ov = d2_ov;
      r.sum = d2_sum; r.cout = d2_cout; r.ovf = d2_ovf; r.zero = d2_zero;
      r.gg = d2_gg; r.gp = d2_gp;
    end else begin
      ir = d1_ir; ov = d1_ov;
      r.sum = {48'd0, d1_sum}; r.cout = d1_cout; r.ovf = d1_ovf; r.zero = d1_zero;
      r.gg = {12'd0, d1_gg}; r.gp = {12'd0, d1_gp};
    end
  endtask

  // pat=1: 8 beats a=i, b=i*0x0101 with out_ready low on cycles 3..5; pat=0: random traffic.
  task automatic stream(input bit big, input int ncyc, input bit pat);
    res_t q[$];
    res_t act, e;
    logic mv [9];
    logic iv, ordy, ci, sb, ir, ov, adv_m;
    logic [63:0] av, bv;
    int stg, w, bi, got, quiet;
    stg = big ? 8 : 2;
    w   = big ? 64 : 16;
    bi  = 0;
    got = 0;
    quiet = ncyc - 3 * stg - 4;
    for (int l = 0; l < 9; l++) mv[l] = 1'b0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      if (pat) begin
        ordy = !(cyc >= 3 && cyc <= 5);
        iv   = (bi < 8);
        av   = 64'(bi);
        bv   = 64'(bi) * 64'h0101;
        ci   = 1'b0;
        sb   = 1'b0;
      end else begin
        ordy = (cyc >= quiet) || ($urandom_range(0, 3) != 0);
        iv   = (cyc < quiet) && ($urandom_range(0, 4) != 0);
        av   = {$urandom, $urandom};
        bv   = {$urandom, $urandom};
        ci   = 1'($urandom_range(0, 1));
        sb   = 1'($urandom_range(0, 1));
      end
      drive(big, iv, av, bv, ci, sb, ordy);
      #1;
      sample(big, ir, ov, act);
      adv_m = !mv[stg] || ordy;
      chk("in_ready", 64'(ir), 64'(adv_m));
      chk("out_valid", 64'(ov), 64'(mv[stg]));
      if (mv[stg]) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard: result present with no beat outstanding");
        end else begin
          e = q[0];
          chk("stream_sum", act.sum, e.sum);
          chk("stream_cout", 64'(act.cout), 64'(e.cout));
          chk("stream_ovf", 64'(act.ovf), 64'(e.ovf));
          chk("stream_zero", 64'(act.zero), 64'(e.zero));
          chk("stream_gg", 64'(act.gg), 64'(e.gg));
          chk("stream_gp", 64'(act.gp), 64'(e.gp));
          if (ordy) begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      if (adv_m) begin
        for (int l = stg; l > 0; l--) mv[l] = mv[l-1];
        mv[0] = iv;
        if (iv) begin
          q.push_back(model(av, bv, ci, sb, w, 4));
          bi++;
        end
      end
      @(negedge clk);
    end
    drive(big, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    chk("drained", 64'(q.size()), 64'd0);
    $display("stream big=%0d pat=%0d: %0d beats accepted, %0d results delivered", big, pat, bi, got);
    if (pat) chk("delivered", 64'(got), 64'd8);
  endtask

  vec_t vt [10];

  initial begin
    vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b1110};
    vt[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 4'b1000, 4'b0110};
    vt[2] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1110};
    vt[3] = '{16'h1234, 16'h5678, 1'b1, 1'b0, 16'h68AD, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
    vt[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0110};
    vt[5] = '{16'h5555, 16'h5555, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b1111};
    vt[6] = '{16'h0003, 16'h0001, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b1110};
    vt[7] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
    vt[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'b1000, 4'b0000};
    vt[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4'b1111, 4'b0000};

    rst_n = 1'b1;
    drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(d1_ov), 64'd0);
    chk("rst_in_ready", 64'(d1_ir), 64'd1);
    chk("rst_sum", 64'(d1_sum), 64'd0);
    chk("rst_flags", 64'({d1_cout, d1_ovf, d1_zero}), 64'd0);
    chk("rst_gg_gp", 64'({d1_gg, d1_gp}), 64'd0);
    chk("rst_big_valid", 64'(d2_ov), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table: one beat at a time, also checking the exact latency.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 64'(vt[i].a), 64'(vt[i].b), vt[i].cin, vt[i].sub, 1'b1);
      for (int c = 0; c <= STG; c++) begin
        @(negedge clk);
        if (c == 0) d1_iv = 1'b0;
        #1;
        if (c < STG) begin
          chk("early_valid", 64'(d1_ov), 64'd0);
        end else begin
          chk("vec_valid", 64'(d1_ov), 64'd1);
          chk("vec_sum", 64'(d1_sum), 64'(vt[i].sum));
          chk("vec_cout", 64'(d1_cout), 64'(vt[i].cout));
          chk("vec_ovf", 64'(d1_ovf), 64'(vt[i].ovf));
          chk("vec_zero", 64'(d1_zero), 64'(vt[i].zero));
          chk("vec_gg", 64'(d1_gg), 64'(vt[i].gg));
          chk("vec_gp", 64'(d1_gp), 64'(vt[i].gp));
        end
      end
      $display("vec %0d: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b zero=%b gg=%b gp=%b",
               i, vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, d1_sum, d1_cout, d1_ovf, d1_zero,
               d1_gg, d1_gp);
    end
    repeat (4) @(negedge clk);

    stream(1'b0, 20, 1'b1);
    repeat (4) @(negedge clk);

    // Mid-flight reset: leave non-zero bubble data at the output, accept two beats, then reset.
    drive(1'b0, 1'b0, 64'hFFFF, 64'hFFFF, 1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    drive(1'b0, 1'b1, 64'h1111, 64'h2222, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b1, 64'h3333, 64'h4444, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(d1_ov), 64'd0);
    chk("midrst_sum", 64'(d1_sum), 64'd0);
    chk("midrst_flags", 64'({d1_cout, d1_ovf, d1_zero}), 64'd0);
    chk("midrst_gg_gp", 64'({d1_gg, d1_gp}), 64'd0);
    chk("midrst_in_ready", 64'(d1_ir), 64'd1);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("no_ghost_valid", 64'(d1_ov), 64'd0);
    end
    drive(1'b0, 1'b1, 64'h00FF, 64'h0F01, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c <= STG; c++) begin
      @(negedge clk);
      if (c == 0) d1_iv = 1'b0;
    end
    #1;
    chk("post_rst_valid", 64'(d1_ov), 64'd1);
    chk("post_rst_sum", 64'(d1_sum), 64'h1000);
    chk("post_rst_flags", 64'({d1_cout, d1_ovf, d1_zero}), 64'd0);
    $display("post-reset beat: a=00ff b=0f01 -> sum=%h", d1_sum);
    repeat (4) @(negedge clk);

    stream(1'b0, 300, 1'b0);
    repeat (4) @(negedge clk);
    stream(1'b1, 300, 1'b0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
